// File: rtl/keycode_report_rx.sv
`default_nettype none
// ============================================================================
//  Module   : keycode_report_rx
//  Purpose  : Assembles 8-byte HID boot-keyboard reports from a byte stream
//             and publishes modifiers/keycodes only when a report completes.
//             Reports that are interrupted, time out, or are ErrorRollOver
//             are counted in a saturating error counter.
//  Revision : 1.0  initial release
// ============================================================================
module keycode_report_rx #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [7:0]  byte_data,
   input  logic        byte_sof,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [31:0] keycode,
   output logic [7:0]  modifiers,
   output logic        report_valid,
   output logic        key_overflow,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   state_t      state_q,   state_d;
   logic [2:0]  idx_q,     idx_d;
   logic [15:0] tcnt_q,    tcnt_d;
   logic [7:0]  buf_q [8];
   logic [7:0]  buf_d [8];
   logic [31:0] keycode_q, keycode_d;
   logic [7:0]  mod_q,     mod_d;
   logic        valid_q,   valid_d;
   logic        ovf_q,     ovf_d;
   logic [7:0]  err_q,     err_d;

   logic        w_accept;
   logic        w_err_inc;
   logic        w_rollover;
   logic [16:0] w_tcnt_inc;

   // Ready is forced high while reset is asserted so upstream never stalls on reset.
   assign byte_ready = !Reset_n || (state_q != ST_COMMIT);
   assign w_accept   = byte_valid && byte_ready;
   assign w_tcnt_inc = {1'b0, tcnt_q} + 17'd1;

   // Byte 7 arrives in the same cycle the report is judged, so it is taken from the bus.
   assign w_rollover = (buf_q[2] == 8'h01) && (buf_q[3] == 8'h01) &&
                       (buf_q[4] == 8'h01) && (buf_q[5] == 8'h01) &&
                       (buf_q[6] == 8'h01) && (byte_data == 8'h01);

   // Next-state logic: report assembly, abort detection and commit of outputs.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      tcnt_d    = tcnt_q;
      buf_d     = buf_q;
      keycode_d = keycode_q;
      mod_d     = mod_q;
      valid_d   = 1'b0;
      ovf_d     = ovf_q;
      err_d     = err_q;
      w_err_inc = 1'b0;

      case (state_q)
         ST_IDLE: begin
            idx_d  = 3'd0;
            tcnt_d = 16'd0;
            // Non-sof bytes here are stray fragments and are dropped.
            if (w_accept && byte_sof) begin
               buf_d[0] = byte_data;
               idx_d    = 3'd1;
               state_d  = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            if (w_accept) begin
               tcnt_d = 16'd0;
               if (byte_sof) begin
                  // A fresh report start abandons the one in progress.
                  w_err_inc = 1'b1;
                  buf_d[0]  = byte_data;
                  idx_d     = 3'd1;
               end else begin
                  buf_d[idx_q] = byte_data;
                  idx_d        = idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     state_d = ST_COMMIT;
                     idx_d   = 3'd0;
                     if (w_rollover) begin
                        w_err_inc = 1'b1;
                     end else begin
                        keycode_d = {buf_q[5], buf_q[4], buf_q[3], buf_q[2]};
                        mod_d     = buf_q[0];
                        ovf_d     = (buf_q[6] != 8'h00) || (byte_data != 8'h00);
                        valid_d   = 1'b1;
                     end
                  end
               end
            end else if (w_tcnt_inc >= {1'b0, TIMEOUT_CYCLES}) begin
               w_err_inc = 1'b1;
               state_d   = ST_IDLE;
               idx_d     = 3'd0;
               tcnt_d    = 16'd0;
            end else begin
               tcnt_d = w_tcnt_inc[15:0];
            end
         end

         ST_COMMIT: begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            tcnt_d  = 16'd0;
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            tcnt_d  = 16'd0;
         end
      endcase

      if (w_err_inc && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= 3'd0;
         tcnt_q    <= 16'd0;
         for (int i = 0; i < 8; i++) begin
            buf_q[i] <= 8'h00;
         end
         keycode_q <= 32'h0;
         mod_q     <= 8'h0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 8'h0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         tcnt_q    <= tcnt_d;
         buf_q     <= buf_d;
         keycode_q <= keycode_d;
         mod_q     <= mod_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

   assign keycode      = keycode_q;
   assign modifiers    = mod_q;
   assign report_valid = valid_q;
   assign key_overflow = ovf_q;
   assign err_count    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_keycode_report_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keycode_report_rx
//  Purpose  : Self-checking bench for keycode_report_rx using a
//             report-level reference model and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keycode_report_rx;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [7:0]  byte_data;
   logic        byte_sof;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] keycode;
   logic [7:0]  modifiers;
   logic        report_valid;
   logic        key_overflow;
   logic [7:0]  err_count;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: what the outputs should hold after each completed transaction.
   logic [31:0] m_key;
   logic [7:0]  m_mod;
   logic        m_ovf;
   logic [7:0]  m_err;

   keycode_report_rx #(.TIMEOUT_CYCLES(16'd8)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .byte_data    (byte_data),
      .byte_sof     (byte_sof),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .keycode      (keycode),
      .modifiers    (modifiers),
      .report_valid (report_valid),
      .key_overflow (key_overflow),
      .err_count    (err_count)
   );

   // Free-running clock.
   always #5 Clk = ~Clk;

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_key = 32'h0;
      m_mod = 8'h0;
      m_ovf = 1'b0;
      m_err = 8'h0;
   endtask

   task automatic err_inc();
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_keycode"},   keycode,      m_key);
      chk({tag, "_modifiers"}, modifiers,    {24'h0, m_mod});
      chk({tag, "_overflow"},  key_overflow, {31'h0, m_ovf});
      chk({tag, "_errcount"},  err_count,    {24'h0, m_err});
   endtask

   task automatic idle(input int n);
      byte_valid = 1'b0;
      byte_sof   = 1'b0;
      repeat (n) @(negedge Clk);
   endtask

   // Called on a negedge; returns on the negedge after the byte was accepted.
   task automatic put_byte(input logic [7:0] d, input logic s);
      int guard;
      guard      = 0;
      byte_data  = d;
      byte_sof   = s;
      byte_valid = 1'b1;
      while (byte_ready !== 1'b1 && guard < 4) begin
         @(negedge Clk);
         guard++;
      end
      if (guard >= 4) chk("ready_wait", {31'h0, byte_ready}, 32'h1);
      @(negedge Clk);
   endtask

   // Sends a full report (byte 0 at rep[7:0]) and checks the commit cycle.
   task automatic send_report(input logic [63:0] rep, input int gapmax, input bit aborts_prev);
      logic rollover;
      if (aborts_prev) err_inc();
      for (int i = 0; i < 8; i++) begin
         put_byte(rep[8*i +: 8], (i == 0));
         if (i < 7 && gapmax > 0) idle(int'($urandom_range(gapmax, 0)));
      end
      rollover = (rep[63:16] == {6{8'h01}});
      if (rollover) begin
         err_inc();
      end else begin
         m_key = rep[47:16];
         m_mod = rep[7:0];
         m_ovf = (rep[63:48] != 16'h0);
      end
      chk("commit_rv",    {31'h0, report_valid}, {31'h0, !rollover});
      chk("commit_ready", {31'h0, byte_ready},   32'h0);
      chk_outputs("commit");
      idle(1);
      chk("rv_pulse",    {31'h0, report_valid}, 32'h0);
      chk("ready_after", {31'h0, byte_ready},   32'h1);
   endtask

   // Starts a report of k bytes, lets it time out, then offers stray bytes.
   task automatic abort_timeout(input int k);
      for (int i = 0; i < k; i++) put_byte(8'($urandom), (i == 0));
      idle(7);
      chk("pre_timeout_err", {24'h0, err_count}, {24'h0, m_err});
      idle(1);
      err_inc();
      chk_outputs("timeout");
      for (int i = 0; i < 3; i++) begin
         put_byte(8'($urandom), 1'b0);
         chk("stray_rv", {31'h0, report_valid}, 32'h0);
      end
      idle(1);
      chk_outputs("stray");
   endtask

   function automatic logic [63:0] rnd_report();
      logic [63:0] r;
      r = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 0) r[63:48] = 16'h0;
      return r;
   endfunction

   initial begin
      int kind;
      Reset_n    = 1'b0;
      byte_valid = 1'b0;
      byte_sof   = 1'b0;
      byte_data  = 8'h00;
      model_reset();

      // Reset values and ready during/after reset.
      repeat (3) @(negedge Clk);
      chk("rst_ready", {31'h0, byte_ready},   32'h1);
      chk("rst_rv",    {31'h0, report_valid}, 32'h0);
      chk_outputs("reset");
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("ready_post_rst", {31'h0, byte_ready}, 32'h1);

      // Basic report with valid held high.
      send_report(64'h0000_0000_5052_0000, 0, 1'b0);
      chk("basic_keycode", keycode, 32'h0000_5052);

      // ErrorRollOver report is ignored apart from the error count.
      send_report(64'h0101_0101_0101_0000, 0, 1'b0);
      chk("rollover_keycode", keycode, 32'h0000_5052);
      chk("rollover_err", {24'h0, err_count}, 32'h1);

      // Overflow bytes, then an all-zero report clears it.
      send_report(64'h0008_0706_0504_0002, 0, 1'b0);
      chk("ovf_keycode", keycode, 32'h0706_0504);
      chk("ovf_flag", {31'h0, key_overflow}, 32'h1);
      send_report(64'h0, 0, 1'b0);
      chk("clr_flag", {31'h0, key_overflow}, 32'h0);

      // Partial report interrupted by a new start of frame.
      for (int i = 0; i < 5; i++) put_byte(8'(i + 8'h10), (i == 0));
      send_report(64'h0000_0000_004F_0000, 0, 1'b1);
      chk("resync_keycode", keycode, 32'h0000_004F);

      // Inter-byte timeout.
      abort_timeout(3);

      // Reset in the middle of a report.
      for (int i = 0; i < 6; i++) put_byte(8'(i + 8'h20), (i == 0));
      byte_valid = 1'b0;
      Reset_n    = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      model_reset();
      chk("midrst_rv", {31'h0, report_valid}, 32'h0);
      chk_outputs("midrst");
      send_report(rnd_report(), 0, 1'b0);

      // Randomized traffic mix.
      for (int it = 0; it < 40; it++) begin
         kind = int'($urandom_range(4, 0));
         case (kind)
            0, 1: send_report(rnd_report(), 7, 1'b0);
            2:    send_report({48'h0101_0101_0101, 8'($urandom), 8'($urandom)}, 3, 1'b0);
            3: begin
               for (int i = 0; i < int'($urandom_range(7, 1)); i++)
                  put_byte(8'($urandom), (i == 0));
               send_report(rnd_report(), 3, 1'b1);
            end
            default: abort_timeout(int'($urandom_range(7, 1)));
         endcase
      end

      // Error counter saturation via repeated start-of-frame bytes.
      for (int i = 0; i < 259; i++) begin
         put_byte(8'($urandom), 1'b1);
         if (i > 0) err_inc();
      end
      send_report(rnd_report(), 0, 1'b1);
      chk("sat_err", {24'h0, err_count}, 32'h0000_00FF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
